// File: rtl/alarma_pkg.sv
// Shared types for the alarm output controller: controller states and modo encodings.
package alarma_pkg;

  typedef enum logic [1:0] {
    REPOSO,
    PREVENCION,
    ALERTA,
    SILENCIO
  } estado_t;

  localparam logic [1:0] MODO_REPOSO = 2'b00;
  localparam logic [1:0] MODO_PREV   = 2'b01;
  localparam logic [1:0] MODO_ALERTA = 2'b10;

endpackage

// File: rtl/generador_tick.sv
// Pattern prescaler: counts 0..TICK_DIV-1 and flags the terminal count as a one-cycle tick.
module generador_tick #(
  parameter int unsigned TICK_DIV = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int unsigned W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [W-1:0] TERMINAL = W'(TICK_DIV - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (cnt == TERMINAL) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + W'(1);
    end
  end

  assign tick = (cnt == TERMINAL);

endmodule

// File: rtl/controlador_alarma.sv
// Arbitrates alerta/prevencion requests onto one buzzer and lamp, with per-level cadence
// and operator silence that re-arms after SILENCIO_TICKS pattern ticks.
module controlador_alarma
  import alarma_pkg::*;
#(
  parameter int unsigned TICK_DIV       = 50000,
  parameter int unsigned ALERTA_ON      = 2,
  parameter int unsigned ALERTA_OFF     = 2,
  parameter int unsigned PREV_ON        = 1,
  parameter int unsigned PREV_OFF       = 7,
  parameter int unsigned SILENCIO_TICKS = 300
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       alarma_alerta,
  input  logic       alarma_prevencion,
  input  logic       silenciar,
  output logic       buzzer,
  output logic       luz_alarma,
  output logic [1:0] modo,
  output logic       silenciado
);

  localparam int unsigned PER_A   = ALERTA_ON + ALERTA_OFF;
  localparam int unsigned PER_P   = PREV_ON + PREV_OFF;
  localparam int unsigned PER_MAX = (PER_A > PER_P) ? PER_A : PER_P;
  localparam int unsigned FW      = (PER_MAX > 1) ? $clog2(PER_MAX) : 1;
  localparam int unsigned SW      = $clog2(SILENCIO_TICKS + 1);

  estado_t       estado, estado_d;
  logic          silencio_origen;
  logic [FW-1:0] fase, fase_d;
  logic [SW-1:0] cnt_silencio;
  logic          tick, cambio, fin_silencio, buzz_d;

  generador_tick #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk   (clk),
    .rst   (rst),
    .clear (cambio),
    .tick  (tick)
  );

  // Silence expires on the tick that would bring the counter to SILENCIO_TICKS.
  assign fin_silencio = tick && (cnt_silencio == SW'(SILENCIO_TICKS - 1));

  always_comb begin
    estado_d = estado;
    case (estado)
      REPOSO: begin
        if (alarma_alerta)          estado_d = ALERTA;
        else if (alarma_prevencion) estado_d = PREVENCION;
      end
      PREVENCION: begin
        if (alarma_alerta)           estado_d = ALERTA;
        else if (!alarma_prevencion) estado_d = REPOSO;
        else if (silenciar)          estado_d = SILENCIO;
      end
      ALERTA: begin
        if (!alarma_alerta)  estado_d = alarma_prevencion ? PREVENCION : REPOSO;
        else if (silenciar)  estado_d = SILENCIO;
      end
      SILENCIO: begin
        if (!alarma_alerta && !alarma_prevencion)  estado_d = REPOSO;
        else if (!silencio_origen && alarma_alerta) estado_d = ALERTA;
        else if (fin_silencio)                      estado_d = alarma_alerta ? ALERTA : PREVENCION;
      end
      default: estado_d = REPOSO;
    endcase
    cambio = (estado_d != estado);

    fase_d = cambio ? '0 : fase;
    if (!cambio && tick) begin
      if (estado == ALERTA)
        fase_d = (32'(fase) == PER_A - 1) ? '0 : fase + FW'(1);
      else if (estado == PREVENCION)
        fase_d = (32'(fase) == PER_P - 1) ? '0 : fase + FW'(1);
    end

    buzz_d = ((estado_d == ALERTA)     && (32'(fase_d) < ALERTA_ON)) ||
             ((estado_d == PREVENCION) && (32'(fase_d) < PREV_ON));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      estado          <= REPOSO;
      silencio_origen <= 1'b0;
      fase            <= '0;
      cnt_silencio    <= '0;
      buzzer          <= 1'b0;
      luz_alarma      <= 1'b0;
      modo            <= MODO_REPOSO;
      silenciado      <= 1'b0;
    end else begin
      estado <= estado_d;
      fase   <= fase_d;
      if (cambio && estado_d == SILENCIO)
        silencio_origen <= (estado == ALERTA);
      if (cambio || estado_d != SILENCIO)
        cnt_silencio <= '0;
      else if (tick)
        cnt_silencio <= cnt_silencio + SW'(1);

      buzzer     <= buzz_d;
      luz_alarma <= (estado_d == SILENCIO) ? 1'b1 : buzz_d;
      silenciado <= (estado_d == SILENCIO);
      case (estado_d)
        REPOSO:     modo <= MODO_REPOSO;
        PREVENCION: modo <= MODO_PREV;
        ALERTA:     modo <= MODO_ALERTA;
        default:    modo <= alarma_alerta ? MODO_ALERTA : MODO_PREV;
      endcase
    end
  end

endmodule

// File: tb/tb_controlador_alarma.sv
// Scoreboard bench for controlador_alarma: stimulus pushes model expectations, a monitor pops and compares.
module tb_controlador_alarma;

  localparam int TD  = 2;
  localparam int AON = 2;
  localparam int AOF = 2;
  localparam int PON = 1;
  localparam int POF = 3;
  localparam int STK = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       alarma_alerta = 1'b0;
  logic       alarma_prevencion = 1'b0;
  logic       silenciar = 1'b0;
  logic       buzzer, luz_alarma, silenciado;
  logic [1:0] modo;

  controlador_alarma #(
    .TICK_DIV       (TD),
    .ALERTA_ON      (AON),
    .ALERTA_OFF     (AOF),
    .PREV_ON        (PON),
    .PREV_OFF       (POF),
    .SILENCIO_TICKS (STK)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .alarma_alerta     (alarma_alerta),
    .alarma_prevencion (alarma_prevencion),
    .silenciar         (silenciar),
    .buzzer            (buzzer),
    .luz_alarma        (luz_alarma),
    .modo              (modo),
    .silenciado        (silenciado)
  );

  always #10 clk = ~clk;

  typedef struct {
    logic       buz;
    logic       luz;
    logic [1:0] modo;
    logic       sil;
    int         esc;
    int         ciclo;
  } esp_t;

  esp_t  cola[$];
  string nombres[0:6] = '{"reset", "prevencion", "preemption", "silence_rearm",
                          "escalation", "reset_silence", "random"};
  int    checks = 0;
  int    failures = 0;
  int    esc = 0;
  int    ciclo = 0;

  // Reference model: mode 0 idle, 1 prevencion, 2 alerta, 3 silenced; timing derived from
  // the number of clock edges since the mode was entered.
  int m_mode = 0;
  int m_age = 0;
  bit m_from_alert = 1'b0;

  task automatic modelo(input bit r, input bit a, input bit p, input bit s, output esp_t e);
    int nxt, per, on;
    e.buz = 1'b0; e.luz = 1'b0; e.modo = 2'b00; e.sil = 1'b0;
    if (r) begin
      m_mode = 0; m_age = 0; m_from_alert = 1'b0;
      return;
    end
    nxt = m_mode;
    case (m_mode)
      0: nxt = a ? 2 : (p ? 1 : 0);
      1: nxt = a ? 2 : (!p ? 0 : (s ? 3 : 1));
      2: nxt = !a ? (p ? 1 : 0) : (s ? 3 : 2);
      default: begin
        if (!a && !p)                      nxt = 0;
        else if (!m_from_alert && a)       nxt = 2;
        else if (m_age + 1 == STK * TD)    nxt = a ? 2 : 1;
      end
    endcase
    if (nxt != m_mode) begin
      if (nxt == 3) m_from_alert = (m_mode == 2);
      m_mode = nxt;
      m_age = 0;
    end else begin
      m_age++;
    end
    per = (m_mode == 2) ? AON + AOF : PON + POF;
    on  = (m_mode == 2) ? AON : PON;
    e.buz  = (m_mode == 1 || m_mode == 2) && (((m_age / TD) % per) < on);
    e.luz  = (m_mode == 3) ? 1'b1 : e.buz;
    e.sil  = (m_mode == 3);
    e.modo = (m_mode == 0) ? 2'b00 : (m_mode == 1) ? 2'b01 : (m_mode == 2) ? 2'b10 :
             (a ? 2'b10 : 2'b01);
  endtask

  task automatic step(input bit r, input bit a, input bit p, input bit s);
    esp_t e;
    @(negedge clk);
    rst = r; alarma_alerta = a; alarma_prevencion = p; silenciar = s;
    @(posedge clk);
    modelo(r, a, p, s, e);
    e.esc = esc;
    e.ciclo = ciclo;
    ciclo++;
    cola.push_back(e);
  endtask

  task automatic steps(input int n, input bit r, input bit a, input bit p, input bit s);
    for (int i = 0; i < n; i++) step(r, a, p, s);
  endtask

  // Monitor: outputs are valid every cycle; sample on the falling edge.
  initial begin
    esp_t e;
    forever begin
      @(negedge clk);
      if (cola.size() > 0) begin
        e = cola.pop_front();
        checks++;
        if (buzzer !== e.buz || luz_alarma !== e.luz || modo !== e.modo || silenciado !== e.sil) begin
          failures++;
          $display("FAIL %s ciclo=%0d got buzzer=%b luz=%b modo=%b silenciado=%b expected buzzer=%b luz=%b modo=%b silenciado=%b",
                   nombres[e.esc], e.ciclo, buzzer, luz_alarma, modo, silenciado,
                   e.buz, e.luz, e.modo, e.sil);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ra, rp, rs, rr;
    esc = 0;
    steps(2, 1, 1, 0, 0);
    steps(3, 0, 1, 0, 0);
    steps(2, 0, 0, 0, 0);

    esc = 1;
    steps(20, 0, 0, 1, 0);
    steps(2, 0, 0, 0, 0);

    esc = 2;
    steps(5, 0, 0, 1, 0);
    steps(12, 0, 1, 1, 0);
    steps(4, 0, 0, 1, 0);
    steps(2, 0, 0, 0, 0);

    esc = 3;
    steps(3, 0, 1, 0, 0);
    step(0, 1, 0, 1);
    steps(4, 0, 1, 0, 0);
    step(0, 1, 0, 1);
    steps(12, 0, 1, 0, 0);
    steps(2, 0, 0, 0, 0);

    esc = 4;
    steps(3, 0, 0, 1, 0);
    step(0, 0, 1, 1);
    steps(3, 0, 0, 1, 0);
    steps(3, 0, 1, 1, 0);
    steps(2, 0, 0, 1, 0);
    step(0, 1, 1, 1);
    steps(3, 0, 1, 1, 0);
    steps(2, 0, 0, 0, 0);

    esc = 5;
    steps(2, 0, 1, 0, 0);
    step(0, 1, 0, 1);
    steps(3, 0, 1, 0, 0);
    step(1, 1, 0, 0);
    steps(10, 0, 1, 0, 0);
    steps(2, 0, 0, 0, 0);

    esc = 6;
    ra = 1'b0; rp = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(29) == 0) ra = ~ra;
      if ($urandom_range(19) == 0) rp = ~rp;
      rs = ($urandom_range(11) == 0);
      rr = ($urandom_range(399) == 0);
      step(rr, ra, rp, rs);
    end

    repeat (3) @(negedge clk);
    checks++;
    if (cola.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending expectations, expected 0", cola.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
